// File: rtl/program_sequencer.sv
// Program counter sequencer with return-address stack.
// Supports SEQ/JUMP/BRANCH/CALL/RET/CLRERR and sticky stack error flags.
module program_sequencer #(
   parameter int unsigned ADDR_W    = 16,
   parameter int unsigned RAS_DEPTH = 8,
   parameter int unsigned RESET_VEC = 0,
   localparam int unsigned DW       = $clog2(RAS_DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic [2:0]        op,
   input  logic              cond,
   input  logic [ADDR_W-1:0] target,
   input  logic [ADDR_W-1:0] offset,
   output logic [ADDR_W-1:0] pc,
   output logic [DW-1:0]     ras_depth,
   output logic              ras_full,
   output logic              ras_empty,
   output logic              ras_ovf,
   output logic              ras_unf
);

   localparam int unsigned IW = $clog2(RAS_DEPTH);

   typedef enum logic [2:0] {
      OP_SEQ    = 3'd0,
      OP_JUMP   = 3'd1,
      OP_BRANCH = 3'd2,
      OP_CALL   = 3'd3,
      OP_RET    = 3'd4,
      OP_CLRERR = 3'd5
   } op_e;

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [DW-1:0]     depth_q, depth_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;
   logic [ADDR_W-1:0] stack_q [RAS_DEPTH];

   logic              push;
   logic [ADDR_W-1:0] pc_inc;
   logic [IW-1:0]     push_idx;
   logic [IW-1:0]     pop_idx;
   logic              full;
   logic              empty;

   assign pc_inc   = pc_q + ADDR_W'(1);
   assign push_idx = IW'(depth_q);
   assign pop_idx  = IW'(depth_q - DW'(1));
   assign full     = (depth_q == DW'(RAS_DEPTH));
   assign empty    = (depth_q == '0);

   always_comb begin
      pc_d    = pc_q;
      depth_d = depth_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      push    = 1'b0;
      if (!stall) begin
         case (op)
            OP_JUMP:   pc_d = target;
            OP_BRANCH: pc_d = cond ? pc_q + offset : pc_inc;
            OP_CALL: begin
               pc_d = target;
               if (full) begin
                  ovf_d = 1'b1;
               end else begin
                  push    = 1'b1;
                  depth_d = depth_q + DW'(1);
               end
            end
            OP_RET: begin
               if (empty) begin
                  pc_d  = pc_inc;
                  unf_d = 1'b1;
               end else begin
                  pc_d    = stack_q[pop_idx];
                  depth_d = depth_q - DW'(1);
               end
            end
            OP_CLRERR: begin
               pc_d  = pc_inc;
               ovf_d = 1'b0;
               unf_d = 1'b0;
            end
            default:   pc_d = pc_inc;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q    <= ADDR_W'(RESET_VEC);
         depth_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         depth_q <= depth_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // Storage is not reset; depth alone defines which entries are live.
   always_ff @(posedge clk) begin
      if (!reset && push) begin
         stack_q[push_idx] <= pc_inc;
      end
   end

   assign pc        = pc_q;
   assign ras_depth = depth_q;
   assign ras_full  = full;
   assign ras_empty = empty;
   assign ras_ovf   = ovf_q;
   assign ras_unf   = unf_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboard bench for program_sequencer against a queue-based model.
// Driver pushes expected post-edge state; monitor pops and compares.
module tb_program_sequencer;

   localparam int ADDR_W = 16;
   localparam int DEPTH  = 8;
   localparam int MASK   = (1 << ADDR_W) - 1;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              stall = 1'b0;
   logic [2:0]        op = 3'd0;
   logic              cond = 1'b0;
   logic [ADDR_W-1:0] target = '0;
   logic [ADDR_W-1:0] offset = '0;
   logic [ADDR_W-1:0] pc;
   logic [3:0]        ras_depth;
   logic              ras_full;
   logic              ras_empty;
   logic              ras_ovf;
   logic              ras_unf;

   program_sequencer #(
      .ADDR_W(ADDR_W),
      .RAS_DEPTH(DEPTH),
      .RESET_VEC(0)
   ) dut (
      .clk(clk),
      .reset(reset),
      .stall(stall),
      .op(op),
      .cond(cond),
      .target(target),
      .offset(offset),
      .pc(pc),
      .ras_depth(ras_depth),
      .ras_full(ras_full),
      .ras_empty(ras_empty),
      .ras_ovf(ras_ovf),
      .ras_unf(ras_unf)
   );

   always #5 clk = ~clk;

   typedef struct {
      int pc;
      int depth;
      bit ovf;
      bit unf;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   int   m_pc;
   int   m_stack[$];
   bit   m_ovf;
   bit   m_unf;

   function automatic void model_reset();
      m_pc = 0;
      m_stack.delete();
      m_ovf = 0;
      m_unf = 0;
   endfunction

   function automatic void model_step(int o, bit c, int t, int off, bit s);
      if (s) return;
      case (o)
         1: m_pc = t;
         2: m_pc = c ? (m_pc + off) & MASK : (m_pc + 1) & MASK;
         3: begin
            if (m_stack.size() < DEPTH) m_stack.push_back((m_pc + 1) & MASK);
            else m_ovf = 1;
            m_pc = t;
         end
         4: begin
            if (m_stack.size() > 0) m_pc = m_stack.pop_back();
            else begin
               m_unf = 1;
               m_pc = (m_pc + 1) & MASK;
            end
         end
         5: begin
            m_ovf = 0;
            m_unf = 0;
            m_pc = (m_pc + 1) & MASK;
         end
         default: m_pc = (m_pc + 1) & MASK;
      endcase
   endfunction

   function automatic exp_t snap();
      exp_t e;
      e.pc = m_pc;
      e.depth = m_stack.size();
      e.ovf = m_ovf;
      e.unf = m_unf;
      return e;
   endfunction

   // Monitor: every edge with a pending expectation is compared.
   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) begin
         exp_t e;
         bit ok;
         e = sb.pop_front();
         ok = (int'(pc) == e.pc) && (int'(ras_depth) == e.depth)
           && (ras_ovf == e.ovf) && (ras_unf == e.unf)
           && (ras_full == (e.depth == DEPTH))
           && (ras_empty == (e.depth == 0));
         n_cmp++;
         if (!ok) begin
            n_bad++;
            $display("FAIL state t=%0t: got pc=%h d=%0d f=%b e=%b o=%b u=%b, want pc=%h d=%0d o=%b u=%b",
                     $time, pc, ras_depth, ras_full, ras_empty,
                     ras_ovf, ras_unf, e.pc[15:0], e.depth, e.ovf, e.unf);
         end
      end
   end

   // Called at a negedge; returns at the following negedge.
   task automatic issue(input int o, input bit c, input int t,
                        input int off, input bit s);
      op = 3'(o);
      cond = c;
      target = 16'(t);
      offset = 16'(off);
      stall = s;
      model_step(o, c, t & MASK, off & MASK, s);
      sb.push_back(snap());
      @(negedge clk);
   endtask

   task automatic async_reset_check();
      reset = 1'b1;
      #1;
      n_cmp++;
      if (pc !== 16'h0000 || ras_depth !== 4'd0 || ras_ovf !== 1'b0
          || ras_unf !== 1'b0 || ras_empty !== 1'b1) begin
         n_bad++;
         $display("FAIL async_reset: got pc=%h d=%0d o=%b u=%b, want pc=0000 d=0 o=0 u=0",
                  pc, ras_depth, ras_ovf, ras_unf);
      end
      model_reset();
      sb.push_back(snap());
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      model_reset();
      @(negedge clk);
      async_reset_check();

      // Sequential and wrap
      repeat (3) issue(0, 0, 0, 0, 0);
      issue(1, 0, 'hFFFF, 0, 0);
      issue(0, 0, 0, 0, 0);

      // Branches around 0x0010, and stall hold
      issue(1, 0, 'h0010, 0, 0);
      issue(2, 1, 0, 'hFFF0, 0);
      issue(1, 0, 'h0010, 0, 0);
      issue(2, 0, 0, 'hFFF0, 0);
      issue(1, 0, 'h0010, 0, 0);
      issue(1, 0, 'h1234, 0, 1);
      issue(3, 1, 'h4444, 0, 1);
      issue(2, 1, 0, 0, 0);

      // Nested call/return
      issue(1, 0, 'h0100, 0, 0);
      issue(3, 0, 'h0200, 0, 0);
      issue(3, 0, 'h0300, 0, 0);
      issue(4, 0, 0, 0, 0);
      issue(4, 0, 0, 0, 0);

      // Fill, overflow, then drain in LIFO order
      for (int i = 0; i < 9; i++) issue(3, 0, 'h1000 + i * 'h10, 0, 0);
      for (int i = 0; i < 8; i++) issue(4, 0, 0, 0, 0);
      issue(5, 0, 0, 0, 0);

      // Underflow and clear from reset
      async_reset_check();
      issue(4, 0, 0, 0, 0);
      issue(5, 0, 0, 0, 0);

      // Reset mid call chain
      for (int i = 0; i < 3; i++) issue(3, 0, 'h0500 + i, 0, 0);
      async_reset_check();
      issue(4, 0, 0, 0, 0);

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         int r;
         int o;
         int off;
         r = int'($urandom_range(0, 99));
         o = int'($urandom_range(0, 7));
         off = ($urandom_range(0, 1) == 1) ? int'($urandom) & MASK
                                           : int'($urandom_range(0, 8)) - 4;
         if (r == 0) async_reset_check();
         else issue(o, 1'($urandom), int'($urandom) & MASK, off, r < 12);
      end

      @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending, want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 Parameter ADDR_W, default 16, width of program counter and address buses (range 8..32).
REQ-002 Parameter RAS_DEPTH, default 8, return-address-stack entries (range 2..64).
REQ-003 Parameter RESET_VEC, default 0, PC value loaded on reset.
REQ-004 Port clk  input  1  clock; all state updates on rising edge.
REQ-005 Port reset  input  1  reset, asynchronous, active-high.
REQ-006 Port stall  input  1  when 1, all state holds for that cycle.
REQ-007 Port op  input  3  operation: 0 SEQ, 1 JUMP, 2 BRANCH, 3 CALL, 4 RET, 5 CLRERR, 6-7 reserved.
REQ-008 Port cond  input  1  branch-taken qualifier, used only by BRANCH.
REQ-009 Port target  input  ADDR_W  absolute address for JUMP/CALL.
REQ-010 Port offset  input  ADDR_W  two's-complement relative displacement for BRANCH.
REQ-011 Port pc  output  ADDR_W  current program counter, registered.
REQ-012 Port ras_depth  output  $clog2(RAS_DEPTH+1)  number of valid stack entries, registered.
REQ-013 Port ras_full  output  1  ras_depth == RAS_DEPTH, combinational from ras_depth.
REQ-014 Port ras_empty  output  1  ras_depth == 0, combinational from ras_depth.
REQ-015 Port ras_ovf  output  1  sticky: CALL attempted while full.
REQ-016 Port ras_unf  output  1  sticky: RET attempted while empty.

Function
REQ-017 Priority: reset > stall > op; with stall=1, pc, stack contents, ras_depth, ras_ovf, ras_unf all hold.
REQ-018 All PC arithmetic modulo 2^ADDR_W; pc+1 at all-ones wraps to 0; pc+offset wraps silently, no flag.
REQ-019 SEQ and reserved ops 6-7: pc <= pc+1; stack unchanged.
REQ-020 JUMP: pc <= target; stack unchanged.
REQ-021 BRANCH: cond=1 -> pc <= pc+offset; cond=0 -> pc <= pc+1; offset 0 with cond=1 holds pc (self-loop).
REQ-022 CALL not full: stack[ras_depth] <= pc+1 (wrapped), ras_depth += 1, pc <= target, same edge.
REQ-023 CALL when full: pc <= target, no push, ras_depth unchanged, ras_ovf <= 1.
REQ-024 RET not empty: pc <= stack[ras_depth-1], ras_depth -= 1, same edge.
REQ-025 RET when empty: pc <= pc+1, ras_depth stays 0, ras_unf <= 1.
REQ-026 CLRERR: ras_ovf <= 0, ras_unf <= 0, pc <= pc+1; stack unchanged.
REQ-027 Latency: every op's effect visible on pc/ras_depth one clk edge after the op is sampled; no combinational path from inputs to pc.
REQ-028 Stack is LIFO; entries above ras_depth are don't-care and never observable on pc.
REQ-029 op, cond, target, offset ignored while stall=1 or reset=1.

Reset
REQ-030 Reset assertion immediately (without clk) sets pc=RESET_VEC, ras_depth=0, ras_ovf=0, ras_unf=0.
REQ-031 Stack storage need not be cleared; reset mid-sequence discards all pending return addresses.
REQ-032 First op after reset deassertion is sampled on the first rising clk edge with reset low.

Verification
REQ-033 Reset then 3x SEQ -> pc 0,1,2,3; ras_empty=1; with ADDR_W=16, JUMP 0xFFFF then SEQ -> pc 0x0000.
REQ-034 pc=0x0010, BRANCH offset=0xFFF0 cond=1 -> pc 0x0000; cond=0 -> pc 0x0011; stall=1 with any op -> pc holds 0x0010.
REQ-035 pc=0x0100, CALL 0x0200, CALL 0x0300, RET, RET -> pc 0x0200, 0x0300, 0x0201, 0x0101; ras_depth 1,2,1,0.
REQ-036 RAS_DEPTH=8: 9 CALLs -> ras_full=1 after 8th, 9th jumps to target with ras_ovf=1 and depth 8; 8 RETs return correct addresses in LIFO order.
REQ-037 From reset, RET -> pc 1, ras_unf=1; CLRERR -> flags clear, pc 2.
REQ-038 Reset asserted between clk edges mid-CALL chain (depth 3) -> pc=RESET_VEC and ras_depth=0 before next edge; subsequent RET sets ras_unf.
